// File: rtl/ex_pipe_pkg.sv
// Shared types and helpers for the EX->MEM->WB pipeline register chain.
// The stage record describes the contents of one pipeline register at the default widths.
package ex_pipe_pkg;

  localparam int DATA_W_DEF = 38;
  localparam int DEST_W_DEF = 3;

  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  load;
    logic [DEST_W_DEF-1:0] dest;
    logic [DATA_W_DEF-1:0] data;
  } ex_stage_t;

  // Width of a stage index that also encodes "no stage" as 0.
  function automatic int stage_idx_w(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/ex_pipe_slot.sv
// One pipeline stage register with async clear, hold, flush and a bubble-cleaning load.
// Flush beats hold, and hold beats a new load.
module ex_pipe_slot
  import ex_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic              i_wr,
  input  logic              i_load,
  input  logic [DEST_W-1:0] i_dest,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_wr,
  output logic              o_load,
  output logic [DEST_W-1:0] o_dest,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic              r_wr;
  logic              r_load;
  logic [DEST_W-1:0] r_dest;
  logic [DATA_W-1:0] r_data;

  // NOTE: state uses non-blocking assignments so every stage samples its
  // upstream neighbour's pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_load  <= 1'b0;
      r_dest  <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_load  <= 1'b0;
      r_dest  <= '0;
      r_data  <= '0;
    end else if (!i_hold) begin
      // An invalid entry is stored with all fields zero so it can never forward.
      r_valid <= i_valid;
      r_wr    <= i_valid & i_wr;
      r_load  <= i_valid & i_load;
      r_dest  <= i_valid ? i_dest : '0;
      r_data  <= i_valid ? i_data : '0;
    end
  end

  assign o_valid = r_valid;
  assign o_wr    = r_wr;
  assign o_load  = r_load;
  assign o_dest  = r_dest;
  assign o_data  = r_data;

endmodule

// File: rtl/ex_pipe_chain.sv
// EX->MEM->WB pipeline register chain with freeze, per-stage flush, forwarding
// lookup (youngest producer wins) and load-use stall detection.
module ex_pipe_chain
  import ex_pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEST_W     = DEST_W_DEF,
  parameter int STAGES     = 2,
  parameter int NUM_SRC    = 2,
  parameter bit ZERO_NOFWD = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    freeze,
  input  logic [STAGES-1:0]                       flush_mask,
  input  logic                                    in_valid,
  input  logic [DATA_W-1:0]                       in_data,
  input  logic [DEST_W-1:0]                       in_dest,
  input  logic                                    in_wr,
  input  logic                                    in_load,
  output logic                                    out_valid,
  output logic [DATA_W-1:0]                       out_data,
  output logic [DEST_W-1:0]                       out_dest,
  output logic                                    out_wr,
  output logic                                    out_load,
  input  logic [NUM_SRC*DEST_W-1:0]               src_id,
  output logic [NUM_SRC-1:0]                      fwd_hit,
  output logic [NUM_SRC*DATA_W-1:0]               fwd_data,
  output logic [NUM_SRC*stage_idx_w(STAGES)-1:0]  fwd_stage,
  output logic                                    load_use_stall
);

  localparam int SW = stage_idx_w(STAGES);

  logic              w_valid [STAGES];
  logic              w_wr    [STAGES];
  logic              w_load  [STAGES];
  logic [DEST_W-1:0] w_dest  [STAGES];
  logic [DATA_W-1:0] w_data  [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      ex_pipe_slot #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_slot (
        .clk(clk), .rst(rst), .i_hold(freeze), .i_flush(flush_mask[k]),
        .i_valid(in_valid), .i_wr(in_wr), .i_load(in_load),
        .i_dest(in_dest), .i_data(in_data),
        .o_valid(w_valid[k]), .o_wr(w_wr[k]), .o_load(w_load[k]),
        .o_dest(w_dest[k]), .o_data(w_data[k])
      );
    end else begin : g_tail
      ex_pipe_slot #(.DATA_W(DATA_W), .DEST_W(DEST_W)) u_slot (
        .clk(clk), .rst(rst), .i_hold(freeze), .i_flush(flush_mask[k]),
        .i_valid(w_valid[k-1]), .i_wr(w_wr[k-1]), .i_load(w_load[k-1]),
        .i_dest(w_dest[k-1]), .i_data(w_data[k-1]),
        .o_valid(w_valid[k]), .o_wr(w_wr[k]), .o_load(w_load[k]),
        .o_dest(w_dest[k]), .o_data(w_data[k])
      );
    end
  end

  assign out_valid = w_valid[STAGES-1];
  assign out_data  = w_data[STAGES-1];
  assign out_dest  = w_dest[STAGES-1];
  assign out_wr    = w_wr[STAGES-1];
  assign out_load  = w_load[STAGES-1];

  // Scan oldest to youngest so the youngest matching producer overrides.
  // NOTE: every output gets a default first so this block cannot infer latches.
  always_comb begin
    fwd_hit        = '0;
    fwd_data       = '0;
    fwd_stage      = '0;
    load_use_stall = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (w_valid[k] && w_wr[k] && (w_dest[k] == src_id[i*DEST_W +: DEST_W]) &&
            !(ZERO_NOFWD && (src_id[i*DEST_W +: DEST_W] == '0))) begin
          fwd_hit[i]                = 1'b1;
          fwd_data[i*DATA_W +: DATA_W] = w_data[k];
          fwd_stage[i*SW +: SW]     = SW'(k + 1);
        end
      end
      if (fwd_hit[i] && (fwd_stage[i*SW +: SW] == SW'(1)) && w_load[0]) begin
        load_use_stall = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_pipe_chain.sv
// Self-checking bench for ex_pipe_chain: directed cases plus randomized traffic
// compared against an array-of-records reference model.
module tb_ex_pipe_chain;
  import ex_pipe_pkg::*;

  localparam int DATA_W  = 38;
  localparam int DEST_W  = 3;
  localparam int STAGES  = 2;
  localparam int NUM_SRC = 2;
  localparam int SW      = stage_idx_w(STAGES);

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       freeze;
  logic [STAGES-1:0]          flush_mask;
  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic [DEST_W-1:0]          in_dest;
  logic                       in_wr;
  logic                       in_load;
  logic                       out_valid;
  logic [DATA_W-1:0]          out_data;
  logic [DEST_W-1:0]          out_dest;
  logic                       out_wr;
  logic                       out_load;
  logic [NUM_SRC*DEST_W-1:0]  src_id;
  logic [NUM_SRC-1:0]         fwd_hit;
  logic [NUM_SRC*DATA_W-1:0]  fwd_data;
  logic [NUM_SRC*SW-1:0]      fwd_stage;
  logic                       load_use_stall;

  ex_pipe_chain #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .STAGES(STAGES), .NUM_SRC(NUM_SRC), .ZERO_NOFWD(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush_mask(flush_mask),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_wr(in_wr), .in_load(in_load),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest), .out_wr(out_wr),
    .out_load(out_load), .src_id(src_id), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .fwd_stage(fwd_stage), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  ex_stage_t m [STAGES];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void model_clear();
    for (int k = 0; k < STAGES; k++) m[k] = '0;
  endfunction

  // One clock edge of the pipeline: shift or hold, then apply flush.
  function automatic void model_edge();
    ex_stage_t nxt [STAGES];
    if (freeze) begin
      for (int k = 0; k < STAGES; k++) nxt[k] = m[k];
    end else begin
      nxt[0] = '0;
      if (in_valid) begin
        nxt[0].valid = 1'b1;
        nxt[0].wr    = in_wr;
        nxt[0].load  = in_load;
        nxt[0].dest  = in_dest;
        nxt[0].data  = in_data;
      end
      for (int k = 1; k < STAGES; k++) nxt[k] = m[k-1];
    end
    for (int k = 0; k < STAGES; k++) if (flush_mask[k]) nxt[k] = '0;
    for (int k = 0; k < STAGES; k++) m[k] = nxt[k];
  endfunction

  task automatic check_all();
    logic              e_stall = 1'b0;
    logic              e_hit;
    logic [DATA_W-1:0] e_data;
    int                e_stage;
    logic [DEST_W-1:0] s;
    check("out_valid", 64'(out_valid), 64'(m[STAGES-1].valid));
    check("out_data",  64'(out_data),  64'(m[STAGES-1].data));
    check("out_dest",  64'(out_dest),  64'(m[STAGES-1].dest));
    check("out_wr",    64'(out_wr),    64'(m[STAGES-1].wr));
    check("out_load",  64'(out_load),  64'(m[STAGES-1].load));
    for (int i = 0; i < NUM_SRC; i++) begin
      s       = src_id[i*DEST_W +: DEST_W];
      e_hit   = 1'b0;
      e_data  = '0;
      e_stage = 0;
      if (s != 0) begin
        for (int k = 0; k < STAGES; k++) begin
          if (!e_hit && m[k].valid && m[k].wr && m[k].dest == s) begin
            e_hit   = 1'b1;
            e_data  = m[k].data;
            e_stage = k + 1;
          end
        end
      end
      if (e_hit && e_stage == 1 && m[0].load) e_stall = 1'b1;
      check($sformatf("fwd_hit[%0d]", i),   64'(fwd_hit[i]), 64'(e_hit));
      check($sformatf("fwd_data[%0d]", i),  64'(fwd_data[i*DATA_W +: DATA_W]), 64'(e_data));
      check($sformatf("fwd_stage[%0d]", i), 64'(fwd_stage[i*SW +: SW]), 64'(e_stage));
    end
    check("load_use_stall", 64'(load_use_stall), 64'(e_stall));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic push(input logic v, input logic [DATA_W-1:0] d, input logic [DEST_W-1:0] id,
                      input logic wr, input logic ld);
    freeze     = 1'b0;
    flush_mask = '0;
    in_valid   = v;
    in_data    = d;
    in_dest    = id;
    in_wr      = wr;
    in_load    = ld;
    step();
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush_mask = '0; in_valid = 1'b0; in_data = '0;
    in_dest = '0; in_wr = 1'b0; in_load = 1'b0; src_id = '0;
    model_clear();
    #2;
    check_all();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    #1 rst = 1'b1;

    // Flow: latency of two edges.
    push(1'b1, 38'h15, 3'd3, 1'b1, 1'b0);
    check("flow_not_yet", 64'(out_valid), 64'd0);
    push(1'b0, 38'h0, 3'd0, 1'b0, 1'b0);
    check("flow_valid", 64'(out_valid), 64'd1);
    check("flow_data", 64'(out_data), 64'h15);

    // Freeze holds B at the output, A appears after resume.
    push(1'b1, 38'hB0B, 3'd1, 1'b1, 1'b0);
    push(1'b1, 38'hA0A, 3'd2, 1'b1, 1'b0);
    freeze = 1'b1; in_data = 38'h3FF;
    for (int c = 0; c < 3; c++) begin
      step();
      check("freeze_hold", 64'(out_data), 64'hB0B);
    end
    push(1'b0, 38'h0, 3'd0, 1'b0, 1'b0);
    check("freeze_resume", 64'(out_data), 64'hA0A);

    // Flush stage 0 while frozen: stage 1 untouched, flushed entry stops forwarding.
    push(1'b1, 38'hD, 3'd6, 1'b1, 1'b0);
    src_id = {3'd6, 3'd4};
    push(1'b1, 38'hC, 3'd4, 1'b1, 1'b0);
    check("pre_flush_hit", 64'(fwd_hit[0]), 64'd1);
    freeze = 1'b1; flush_mask = 2'b01;
    step();
    check("flush_no_fwd", 64'(fwd_hit[0]), 64'd0);
    check("flush_keep_s1", 64'(out_data), 64'hD);
    check("flush_s1_stage", 64'(fwd_stage[SW +: SW]), 64'd2);

    // Youngest producer wins; id 0 never forwards.
    src_id = {3'd0, 3'd5};
    push(1'b1, 38'hBB, 3'd5, 1'b1, 1'b0);
    push(1'b1, 38'hAA, 3'd5, 1'b1, 1'b0);
    check("fwd_young_hit", 64'(fwd_hit[0]), 64'd1);
    check("fwd_young_data", 64'(fwd_data[DATA_W-1:0]), 64'hAA);
    check("fwd_young_stage", 64'(fwd_stage[SW-1:0]), 64'd1);
    src_id = {3'd0, 3'd0};
    push(1'b1, 38'h77, 3'd0, 1'b1, 1'b0);
    check("fwd_zero_id", 64'(fwd_hit), 64'd0);

    // Load-use stall only while the load sits in stage 0.
    src_id = {3'd2, 3'd7};
    push(1'b1, 38'h22, 3'd2, 1'b1, 1'b1);
    check("lu_stall", 64'(load_use_stall), 64'd1);
    check("lu_hit", 64'(fwd_hit[1]), 64'd1);
    push(1'b0, 38'h0, 3'd0, 1'b0, 1'b0);
    check("lu_clear", 64'(load_use_stall), 64'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      freeze     = ($urandom_range(0, 3) == 0);
      flush_mask = STAGES'({($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)});
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = DATA_W'({$urandom(), $urandom()});
      in_dest    = DEST_W'($urandom());
      in_wr      = ($urandom_range(0, 3) != 0);
      in_load    = $urandom_range(0, 1) == 1;
      src_id     = (NUM_SRC*DEST_W)'($urandom());
      step();
    end

    // Asynchronous reset mid-cycle with entries in flight.
    push(1'b1, 38'h3A, 3'd1, 1'b1, 1'b0);
    src_id = {3'd1, 3'd1};
    freeze = 1'b0; in_valid = 1'b1; in_data = 38'h3B; in_dest = 3'd1;
    @(posedge clk);
    model_edge();
    #3 rst = 1'b0;
    #1;
    model_clear();
    check_all();
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_hit", 64'(fwd_hit), 64'd0);
    #2 rst = 1'b1;
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
